// File: rtl/vrased_reset_seq_pkg.sv
// Shared types and constants for the VRASED reset sequencer: state encoding,
// default reset-handler address, monitor request bit positions.
package vrased_reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_ARM    = 2'd2
  } state_e;

  localparam logic [15:0] RESET_HANDLER_DEF = 16'h0000;

  localparam int REQ_STACK = 0;
  localparam int REQ_ATOM  = 1;
  localparam int REQ_AC    = 2;

  // Down-counter width able to hold max(a,b)-1, never narrower than 1 bit.
  function automatic int timer_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/vrased_sat_counter.sv
// Saturating up-counter; sticks at all-ones, cleared only by clr.
module vrased_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (inc && (q_q != '1)) q_d = q_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (clr) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/vrased_reset_seq.sv
// Turns level reset requests from the VRASED monitors into a fixed-width
// registered core reset, with a re-arm window and sticky cause / count readout.
module vrased_reset_seq
  import vrased_reset_seq_pkg::*;
#(
  parameter logic [15:0] RESET_HANDLER = RESET_HANDLER_DEF,
  parameter int          NREQ          = 3,
  parameter int          RST_CYCLES    = 4,
  parameter int          ARM_TIMEOUT   = 16,
  parameter int          CNT_W         = 8
) (
  input  logic             mclk,
  input  logic             por,
  input  logic [NREQ-1:0]  viol_req,
  input  logic [15:0]      pc,
  input  logic             cause_clr,
  output logic             sys_rst,
  output logic [NREQ-1:0]  cause,
  output logic [CNT_W-1:0] viol_cnt,
  output logic             busy
);

  localparam int          TW       = timer_w(RST_CYCLES, ARM_TIMEOUT);
  localparam logic [TW-1:0] RST_LOAD = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] ARM_LOAD = TW'(ARM_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [TW-1:0]   rst_tmr_q, rst_tmr_d;
  logic [TW-1:0]   arm_tmr_q, arm_tmr_d;
  logic [NREQ-1:0] cause_q, cause_d;
  logic            sys_rst_q, sys_rst_d;
  logic            busy_q, busy_d;
  logic            cnt_inc;
  logic            req_any;

  assign req_any = |viol_req;

  always_comb begin
    state_d   = state_q;
    rst_tmr_d = rst_tmr_q;
    arm_tmr_d = arm_tmr_q;
    cause_d   = cause_q;
    cnt_inc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          state_d   = ST_ASSERT;
          rst_tmr_d = RST_LOAD;
          // A coincident clear drops old history; the new violation survives.
          cause_d   = (cause_clr ? '0 : cause_q) | viol_req;
          cnt_inc   = 1'b1;
        end else if (cause_clr) begin
          cause_d = '0;
        end
      end
      ST_ASSERT: begin
        if (rst_tmr_q == '0) begin
          state_d   = ST_ARM;
          arm_tmr_d = ARM_LOAD;
        end else begin
          rst_tmr_d = rst_tmr_q - TW'(1);
        end
      end
      ST_ARM: begin
        if ((pc == RESET_HANDLER) && !req_any) begin
          state_d = ST_IDLE;
        end else if (arm_tmr_q == '0) begin
          if (req_any) begin
            state_d   = ST_ASSERT;
            rst_tmr_d = RST_LOAD;
            cause_d   = cause_q | viol_req;
            cnt_inc   = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          arm_tmr_d = arm_tmr_q - TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    sys_rst_d = (state_d == ST_ASSERT);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge mclk) begin
    if (por) begin
      state_q   <= ST_IDLE;
      rst_tmr_q <= '0;
      arm_tmr_q <= '0;
      cause_q   <= '0;
      sys_rst_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_tmr_q <= rst_tmr_d;
      arm_tmr_q <= arm_tmr_d;
      cause_q   <= cause_d;
      sys_rst_q <= sys_rst_d;
      busy_q    <= busy_d;
    end
  end

  vrased_sat_counter #(.W(CNT_W)) u_viol_cnt (
    .clk (mclk),
    .clr (por),
    .inc (cnt_inc),
    .q   (viol_cnt)
  );

  assign sys_rst = sys_rst_q;
  assign cause   = cause_q;
  assign busy    = busy_q;

endmodule
